// File: rtl/ternary_neuron_acc.sv
// Purpose: N-input ternary-weight neuron. It accumulates signed synapse sums over FRAME_LEN valid vectors and compares each frame result with a threshold.
// Latency: y, fire and y_valid are registered. They update one cycle after the final x_valid of a frame.
// Backpressure: none. y_valid pulses for one cycle, and y/fire hold their values until the next frame end.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   w_shift, w_bit   serial weight load; each synapse uses 2 bits, shifted in at w[0]
//   clear            synchronous frame abort; zeroes the accumulator and frame counter
//   x_valid, x       binary input vector (N_INPUTS bits)
//   threshold        signed fire threshold, sampled at frame end
//   y_valid, y, fire frame result pulse, signed result, and (y >= threshold)
//   weights_ok       high once 2*N_INPUTS shifts have occurred since reset
//
// Build option: define SATURATE_EN to clamp every accumulate step to the signed ACC_W range.
// Without it, the accumulator wraps in two's complement.
module ternary_neuron_acc #(
  parameter int N_INPUTS  = 8,
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_shift,
  input  logic                w_bit,
  input  logic                clear,
  input  logic                x_valid,
  input  logic [N_INPUTS-1:0] x,
  input  logic [ACC_W-1:0]    threshold,
  output logic                y_valid,
  output logic [ACC_W-1:0]    y,
  output logic                fire,
  output logic                weights_ok
);

  localparam int W_BITS = 2 * N_INPUTS;
  localparam int PS_W   = $clog2(N_INPUTS + 1) + 1;
  localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int SC_W   = $clog2(W_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [SC_W-1:0]  SC_FULL  = SC_W'(W_BITS);

  logic [W_BITS-1:0]      w;
  logic [SC_W-1:0]        shift_cnt;
  logic [CNT_W-1:0]       cnt;
  logic [ACC_W-1:0]       acc;
  logic signed [PS_W-1:0] psum;
  logic [ACC_W-1:0]       acc_next;

  // Weight shift register. After reset all bits are ones, so every synapse is a zero weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w <= '1;
    end else if (w_shift) begin
      w <= {w[W_BITS-2:0], w_bit};
    end
  end

  // Saturating shift counter. Only reset clears it; a frame clear does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_cnt <= '0;
    end else if (w_shift && (shift_cnt != SC_FULL)) begin
      shift_cnt <= shift_cnt + SC_W'(1);
    end
  end

  assign weights_ok = (shift_cnt == SC_FULL);

  // Per-cycle partial sum. For synapse i, zero = w[2i] and sign = w[2i+1].
  // This logic reads the pre-shift weights. A concurrent w_shift therefore takes effect on the next cycle.
  always_comb begin
    psum = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (x[i] && !w[2*i]) begin
        if (w[2*i+1]) begin
          psum = psum - PS_W'(1);
        end else begin
          psum = psum + PS_W'(1);
        end
      end
    end
  end

`ifdef SATURATE_EN
  // The sum uses one guard bit. Overflow shows up as a mismatch between the top two bits.
  // On overflow, the result clamps toward the sign of the true sum.
  logic signed [ACC_W:0] sum_full;

  assign sum_full = $signed({acc[ACC_W-1], acc}) + (ACC_W+1)'(psum);

  always_comb begin
    acc_next = sum_full[ACC_W-1:0];
    if (sum_full[ACC_W] != sum_full[ACC_W-1]) begin
      acc_next = {sum_full[ACC_W], {(ACC_W-1){~sum_full[ACC_W]}}};
    end
  end
`else
  logic signed [ACC_W-1:0] sum_wrap;

  assign sum_wrap = $signed(acc) + ACC_W'(psum);
  assign acc_next = sum_wrap;
`endif

  // Frame accumulation and result registers.
  // Priority within a cycle: clear first, then x_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      y       <= '0;
      fire    <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (x_valid) begin
        if (cnt == CNT_LAST) begin
          y       <= acc_next;
          fire    <= ($signed(acc_next) >= $signed(threshold));
          y_valid <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Bench for ternary_neuron_acc. A behavioural model tracks weights, frame sums and outputs as plain integers.
// The bench compares every output against this model on every falling edge.
// It runs directed scenarios with literal expectations, then randomized traffic.
module tb_ternary_neuron_acc;

  localparam int N  = 8;
  localparam int FL = 4;
  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic          w_shift, w_bit, clear, x_valid;
  logic [N-1:0]  x;
  logic [AW-1:0] threshold;
  logic          y_valid, fire, weights_ok;
  logic [AW-1:0] y;

  // Second instance sized to exercise accumulator overflow (FRAME_LEN=8, ACC_W=6).
  logic          s_shift, s_bit, s_clear, s_xv;
  logic [N-1:0]  s_x;
  logic [5:0]    s_thr;
  logic          s_yv, s_fire, s_wok;
  logic [5:0]    s_y;

  ternary_neuron_acc #(.N_INPUTS(N), .FRAME_LEN(FL), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .w_shift(w_shift), .w_bit(w_bit), .clear(clear),
    .x_valid(x_valid), .x(x), .threshold(threshold), .y_valid(y_valid), .y(y),
    .fire(fire), .weights_ok(weights_ok)
  );

  ternary_neuron_acc #(.N_INPUTS(N), .FRAME_LEN(8), .ACC_W(6)) dut_sat (
    .clk(clk), .rst_n(rst_n), .w_shift(s_shift), .w_bit(s_bit), .clear(s_clear),
    .x_valid(s_xv), .x(s_x), .threshold(s_thr), .y_valid(s_yv), .y(s_y),
    .fire(s_fire), .weights_ok(s_wok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int yv_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit wb[2*N];
  int m_acc = 0, m_cnt = 0, m_shifts = 0;
  int exp_y = 0;
  bit exp_fire = 0, exp_yv = 0, exp_wok = 0;
  int mv;

  function automatic int fix(input int v, input int aw);
    int m = 1 << aw;
    int r;
`ifdef SATURATE_EN
    if (v > m/2 - 1) r = m/2 - 1;
    else if (v < -(m/2)) r = -(m/2);
    else r = v;
`else
    r = ((v % m) + m) % m;
    if (r >= m/2) r -= m;
`endif
    return r;
  endfunction

  function automatic int weight_of(input int i);
    if (wb[2*i]) return 0;
    return wb[2*i+1] ? -1 : 1;
  endfunction

  function automatic int syn_sum(input logic [N-1:0] xv);
    int s = 0;
    for (int i = 0; i < N; i++) if (xv[i]) s += weight_of(i);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2*N; k++) wb[k] = 1'b1;
      m_acc = 0; m_cnt = 0; m_shifts = 0;
      exp_y = 0; exp_fire = 0; exp_yv = 0; exp_wok = 0;
    end else begin
      exp_yv = 0;
      if (clear) begin
        m_acc = 0; m_cnt = 0;
      end else if (x_valid) begin
        mv = fix(m_acc + syn_sum(x), AW);
        if (m_cnt == FL - 1) begin
          exp_y = mv;
          exp_fire = (mv >= int'($signed(threshold)));
          exp_yv = 1;
          m_acc = 0; m_cnt = 0;
        end else begin
          m_acc = mv; m_cnt++;
        end
      end
      if (w_shift) begin
        for (int k = 2*N-1; k > 0; k--) wb[k] = wb[k-1];
        wb[0] = w_bit;
        if (m_shifts < 2*N) m_shifts++;
      end
      exp_wok = (m_shifts >= 2*N);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("y_valid", int'(y_valid), int'(exp_yv));
    chk("y", int'($signed(y)), exp_y);
    chk("fire", int'(fire), int'(exp_fire));
    chk("weights_ok", int'(weights_ok), int'(exp_wok));
    if (y_valid) yv_count++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit sh, input bit b, input bit cl, input bit xv, input logic [N-1:0] xx);
    w_shift = sh; w_bit = b; clear = cl; x_valid = xv; x = xx;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0);
  endtask

  task automatic load_all_plus();
    for (int k = 0; k < 2*N; k++) drive(1, 0, 0, 0, '0);
  endtask

  int yc0;
  int sat_exp;

  initial begin
    rst_n = 1'b0;
    w_shift = 0; w_bit = 0; clear = 0; x_valid = 0; x = '0; threshold = '0;
    s_shift = 0; s_bit = 0; s_clear = 0; s_xv = 0; s_x = '0; s_thr = '0;
    @(negedge clk); #1;
    chk("reset_y", int'(y), 0);
    chk("reset_yv", int'(y_valid), 0);
    chk("reset_wok", int'(weights_ok), 0);
    rst_n = 1'b1;
    idle();

    // All +1 weights: weights_ok rises only after the 16th shift.
    for (int k = 0; k < 2*N-1; k++) drive(1, 0, 0, 0, '0);
    chk("wok_after_15", int'(weights_ok), 0);
    drive(1, 0, 0, 0, '0);
    chk("wok_after_16", int'(weights_ok), 1);
    threshold = 10'd20;
    yc0 = yv_count;
    for (int k = 0; k < FL; k++) drive(0, 0, 0, 1, 8'hFF);
    chk("allplus_yv", int'(y_valid), 1);
    chk("allplus_y", int'($signed(y)), 32);
    chk("allplus_fire", int'(fire), 1);
    idle();
    chk("allplus_pulse_end", int'(y_valid), 0);
    chk("allplus_hold", int'($signed(y)), 32);
    chk("allplus_one_pulse", yv_count - yc0, 1);

    // Mixed sign: synapse 0 = -1, all others zero.
    for (int k = 0; k < 14; k++) drive(1, 1, 0, 0, '0);
    drive(1, 1, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    threshold = 10'd0;
    for (int k = 0; k < FL; k++) drive(0, 0, 0, 1, 8'hFF);
    chk("mixed_y", int'($signed(y)), -4);
    chk("mixed_fire", int'(fire), 0);

    // Asynchronous reset mid-frame (cnt=2).
    drive(0, 0, 0, 1, 8'hFF);
    drive(0, 0, 0, 1, 8'hFF);
    x_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_y", int'(y), 0);
    chk("arst_fire", int'(fire), 0);
    chk("arst_yv", int'(y_valid), 0);
    chk("arst_wok", int'(weights_ok), 0);
    rst_n = 1'b1;
    load_all_plus();
    threshold = 10'd3;
    yc0 = yv_count;
    for (int k = 0; k < FL-1; k++) drive(0, 0, 0, 1, 8'h01);
    chk("post_rst_no_early_yv", yv_count - yc0, 0);
    drive(0, 0, 0, 1, 8'h01);
    chk("post_rst_y", int'($signed(y)), 4);
    chk("post_rst_fire", int'(fire), 1);

    // Clear, then a gapped frame.
    threshold = 10'd20;
    drive(0, 0, 0, 1, 8'hFF);
    drive(0, 0, 0, 1, 8'hFF);
    drive(0, 0, 1, 1, 8'hFF);
    yc0 = yv_count;
    for (int k = 0; k < FL; k++) begin
      drive(0, 0, 0, 1, 8'h0F);
      idle();
    end
    chk("clear_y", int'($signed(y)), 16);
    chk("clear_fire", int'(fire), 0);
    chk("clear_one_pulse", yv_count - yc0, 1);

    // Concurrent shift on the final vector: the old weights apply to this frame.
    for (int k = 0; k < FL-1; k++) drive(0, 0, 0, 1, 8'hFF);
    drive(1, 1, 0, 1, 8'hFF);
    chk("conc_old_y", int'($signed(y)), 32);
    for (int k = 0; k < FL; k++) drive(0, 0, 0, 1, 8'hFF);
    chk("conc_new_y", int'($signed(y)), 28);
    chk("conc_new_fire", int'(fire), 1);

    // Overflow on the narrow instance.
`ifdef SATURATE_EN
    sat_exp = 31;
`else
    sat_exp = 0;
`endif
    for (int k = 0; k < 2*N; k++) begin
      s_shift = 1; s_bit = 0;
      @(negedge clk); #1;
    end
    s_shift = 0;
    chk("sat_wok", int'(s_wok), 1);
    s_x = 8'hFF;
    s_xv = 1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); #1;
    end
    chk("sat_no_early_yv", int'(s_yv), 0);
    @(negedge clk); #1;
    s_xv = 0;
    chk("sat_yv", int'(s_yv), 1);
    chk("sat_y", int'($signed(s_y)), sat_exp);
    chk("sat_fire", int'(s_fire), 1);

    // Randomized traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      threshold = AW'($urandom_range(0, (1 << AW) - 1));
      drive(($urandom_range(0, 9) == 0), 1'($urandom), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 7), N'($urandom));
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ternary_neuron_acc.md
# ternary_neuron_acc

Parametrised ternary-weight neuron: N binary inputs, each multiplied by a serially loaded weight in {-1, 0, +1}. Products are summed per cycle and accumulated over a fixed frame of valid input vectors. At frame end the block emits a signed result plus a threshold-compare "fire" flag. It is the multi-cycle, N-wide successor of the 4-synapse combinational adder tree and sits between the input pad mux and the output pins of the neural-net tile.

## Interface
- N_INPUTS, 8: number of synapses / input bits; must be ≥1.
- FRAME_LEN, 4: valid input vectors accumulated per output; must be ≥1.
- ACC_W, 10: accumulator/result width, signed; must be ≥ clog2(N_INPUTS+1)+1.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- w_shift  in  1  shift one weight bit into the weight register this cycle.
- w_bit  in  1  serial weight bit.
- clear  in  1  synchronous frame abort: zero accumulator and frame counter.
- x_valid  in  1  x carries a valid input vector this cycle.
- x  in  N_INPUTS  binary input vector.
- threshold  in  ACC_W  signed fire threshold, sampled at frame end.
- y_valid  out  1  one-cycle pulse, y/fire updated.
- y  out  ACC_W  signed frame result, held until next frame end.
- fire  out  1  registered (y ≥ threshold), held with y.
- weights_ok  out  1  high once ≥2·N_INPUTS shifts have occurred since reset.

## Operation
- Weight register w[2N-1:0]. On w_shift: w ← {w[2N-2:0], w_bit}. Synapse i uses zero = w[2i] and sign = w[2i+1].
- Synapse product p_i = 0 if (!x[i] || zero), −1 if sign, else +1.
- Per-cycle partial sum s = Σp_i, signed, range [−N, +N], width clog2(N+1)+1, sign-extended to ACC_W+1 for the add.
- Frame counter cnt: 0..FRAME_LEN−1. Accumulator acc: ACC_W signed.
- Priority per cycle: rst_n, then clear, then x_valid.
- clear: acc ← 0, cnt ← 0, no y_valid. The x on that cycle is dropped.
- x_valid with cnt < FRAME_LEN−1: acc ← acc+s (arith rule below), cnt ← cnt+1.
- x_valid with cnt = FRAME_LEN−1:
  - y ← acc+s (arith rule below).
  - fire ← (that value ≥ threshold), signed compare.
  - y_valid ← 1.
  - acc ← 0, cnt ← 0.
- FRAME_LEN=1: every valid vector produces an output.
- Cycles without x_valid change neither acc nor cnt. Gaps are legal.
- w_shift concurrent with x_valid: s uses pre-shift w; the new weights apply from the next cycle. Shifting mid-frame is legal.
- Shift counter saturates at 2N and sets weights_ok. It is cleared only by reset, not by clear.

## Timing
- Reset values:
  - w = all ones (every weight 0).
  - acc = 0, cnt = 0.
  - y = 0, fire = 0, y_valid = 0, weights_ok = 0.
- Reset mid-frame discards the partial frame immediately (asynchronous).
- Latency: y, fire and y_valid are valid the cycle after the final x_valid edge. y_valid is high for exactly one cycle.
- Back-to-back frames with continuous x_valid produce y_valid every FRAME_LEN cycles.
- No backpressure. The consumer must capture y on y_valid, or read the held y later.
- weights_ok rises the cycle after the 2N-th w_shift edge.

## Configuration
- SATURATE_EN defined: each acc+s and the final y clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. Overflow never changes sign.
- SATURATE_EN undefined: two's-complement wrap at ACC_W bits, with no clamp logic.

## Test plan
- Reset: drive rst_n low mid-frame (cnt=2) → y=0, fire=0, y_valid=0, weights_ok=0 asynchronously. The next frame needs 4 fresh vectors.
- All +1 (N=8, FRAME_LEN=4, ACC_W=10): shift 16 zeros → weights_ok after the 16th shift. Then x=0xFF ×4 with threshold=20 → y=32, fire=1, y_valid pulses once.
- Mixed sign: synapse0 = −1, others 0. Shift 14 ones, then bit 1, then bit 0; the last bit shifted in lands in w[0]=zero=0 and w[1]=sign=1. Then x=0xFF ×4 with threshold=0 → y=−4, fire=0.
- Saturation: N=8, FRAME_LEN=8, ACC_W=6, all +1, x=0xFF ×8 → y=31 with SATURATE_EN. Without it, y=0 (64 wraps).
- Clear and gaps: 2 valid vectors, then clear, then 4 vectors of x=0x0F interleaved with idle cycles (all +1) → y=16, exactly one y_valid.
- Concurrent shift: w_shift asserted on the same cycle as the final x_valid → y computed with the old weights; the following frame uses the new weights.
